// File: rtl/serial_shift_unit.sv
// Iterative SLL/SRL/SRA unit that shifts at most CHUNK bits per cycle.
// It returns the result over a valid/ready handshake and holds busy high until the result is consumed.
module serial_shift_unit #(
  parameter int WIDTH = 32,
  parameter int CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [6:0]       in_alu_ctl,
  input  logic [WIDTH-1:0] in_a,
  input  logic [4:0]       in_shamt,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_result,
  output logic             out_illegal,
  output logic             busy
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
  typedef enum logic [1:0] {OP_SLL, OP_SRL, OP_SRA} op_t;

  localparam logic [6:0] CTL_SLL = 7'b0000101;
  localparam logic [6:0] CTL_SRL = 7'b0000011;
  localparam logic [6:0] CTL_SRA = 7'b0000100;
  localparam logic [5:0] CHUNK_V = 6'(CHUNK);

  state_t           state, state_next;
  op_t              op, op_dec;
  logic [WIDTH-1:0] acc;
  logic [4:0]       rem;
  logic             illegal, illegal_dec;
  logic             accept;
  logic [4:0]       step;

  // min(rem, CHUNK); the result never exceeds rem, so it always fits in 5 bits.
  function automatic logic [4:0] step_amt(input logic [4:0] r);
    if ({1'b0, r} < CHUNK_V) return r;
    else                     return CHUNK_V[4:0];
  endfunction

  function automatic logic [WIDTH-1:0] shift_step(input op_t o, input logic [WIDTH-1:0] v,
                                                  input logic [4:0] s);
    logic signed [WIDTH-1:0] sv;
    sv = $signed(v);
    case (o)
      OP_SLL:  return v << s;
      OP_SRL:  return v >> s;
      default: return $unsigned(sv >>> s);
    endcase
  endfunction

  always_comb begin
    op_dec      = OP_SLL;
    illegal_dec = 1'b0;
    case (in_alu_ctl)
      CTL_SLL: op_dec = OP_SLL;
      CTL_SRL: op_dec = OP_SRL;
      CTL_SRA: op_dec = OP_SRA;
      default: illegal_dec = 1'b1;
    endcase
  end

  assign accept = in_valid && in_ready;
  assign step   = step_amt(rem);

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Next-state logic; flush overrides everything but reset
  always_comb begin
    state_next = state;
    if (accept) begin
      state_next = (illegal_dec || in_shamt == 5'd0) ? DONE : BUSY;
    end else begin
      case (state)
        IDLE:    state_next = IDLE;
        BUSY:    if ({1'b0, rem} <= CHUNK_V) state_next = DONE;
        DONE:    if (out_ready) state_next = IDLE;
        default: state_next = IDLE;
      endcase
    end
    if (flush) state_next = IDLE;
  end

  // Outputs
  always_comb begin
    out_valid = (state == DONE);
    busy      = (state != IDLE);
    in_ready  = !flush && ((state == IDLE) || (state == DONE && out_ready));
  end

  // Datapath: capture at accept, one chunk per BUSY cycle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc     <= '0;
      rem     <= '0;
      op      <= OP_SLL;
      illegal <= 1'b0;
    end else if (flush) begin
      rem <= '0;
    end else if (accept) begin
      acc     <= illegal_dec ? '0 : in_a;
      rem     <= in_shamt;
      op      <= op_dec;
      illegal <= illegal_dec;
    end else if (state == BUSY) begin
      acc <= shift_step(op, acc, step);
      rem <= rem - step;
    end
  end

  assign out_result  = acc;
  assign out_illegal = illegal;

endmodule

// File: tb/tb_serial_shift_unit.sv
// Directed bench for serial_shift_unit: latency, shift results, illegal codes,
// backpressure, back-to-back accept, flush and asynchronous reset.
module tb_serial_shift_unit;

  localparam logic [6:0] SLL = 7'b0000101;
  localparam logic [6:0] SRL = 7'b0000011;
  localparam logic [6:0] SRA = 7'b0000100;
  localparam logic [6:0] BAD = 7'b0000010;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [6:0]  in_alu_ctl;
  logic [31:0] in_a;
  logic [4:0]  in_shamt;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_result;
  logic        out_illegal;
  logic        busy;

  int total = 0;
  int bad   = 0;

  serial_shift_unit #(.WIDTH(32), .CHUNK(4)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_alu_ctl(in_alu_ctl),
    .in_a(in_a), .in_shamt(in_shamt), .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_result(out_result), .out_illegal(out_illegal), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // Present a request for one clock edge, starting just after a falling edge.
  task automatic issue(input string tag, input logic [6:0] ctl, input logic [31:0] a,
                       input logic [4:0] sh);
    in_valid   = 1'b1;
    in_alu_ctl = ctl;
    in_a       = a;
    in_shamt   = sh;
    #1 chk({tag, "_in_ready"}, 32'(in_ready), 32'd1);
    @(negedge clk);
    in_valid   = 1'b0;
    in_alu_ctl = 7'h7f;
    in_a       = 32'h5a5a5a5a;
    in_shamt   = 5'd17;
  endtask

  // Count cycles after the accept edge until out_valid, with a bound.
  task automatic wait_out(input string tag, input int exp_lat, input logic [31:0] exp_res,
                          input logic exp_ill);
    int lat;
    lat = 1;
    while (!out_valid && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    chk({tag, "_latency"}, 32'(lat), 32'(exp_lat));
    chk({tag, "_result"}, out_result, exp_res);
    chk({tag, "_illegal"}, 32'(out_illegal), 32'(exp_ill));
  endtask

  task automatic consume(input string tag);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk({tag, "_consumed"}, 32'(out_valid), 32'd0);
  endtask

  // Watch a number of cycles and report whether out_valid ever rose.
  task automatic no_output(input string tag, input int cycles);
    logic seen;
    seen = 1'b0;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      if (out_valid) seen = 1'b1;
    end
    chk({tag, "_no_output"}, 32'(seen), 32'd0);
  endtask

  initial begin
    rst        = 1'b1;
    in_valid   = 1'b0;
    in_alu_ctl = 7'd0;
    in_a       = 32'd0;
    in_shamt   = 5'd0;
    flush      = 1'b0;
    out_ready  = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_result", out_result, 32'd0);
    chk("rst_illegal", 32'(out_illegal), 32'd0);
    rst = 1'b0;
    #1 chk("post_rst_in_ready", 32'(in_ready), 32'd1);
    @(negedge clk);

    // SLL 1 by 31: eight chunk steps
    issue("sll31", SLL, 32'h00000001, 5'd31);
    chk("sll31_busy", 32'(busy), 32'd1);
    chk("sll31_in_ready_busy", 32'(in_ready), 32'd0);
    wait_out("sll31", 9, 32'h80000000, 1'b0);
    consume("sll31");

    issue("sra4", SRA, 32'h80000000, 5'd4);
    wait_out("sra4", 2, 32'hF8000000, 1'b0);
    consume("sra4");

    issue("srl4", SRL, 32'h80000000, 5'd4);
    wait_out("srl4", 2, 32'h08000000, 1'b0);
    consume("srl4");

    issue("srl0", SRL, 32'hDEADBEEF, 5'd0);
    wait_out("srl0", 1, 32'hDEADBEEF, 1'b0);
    consume("srl0");

    issue("illegal", BAD, 32'h12345678, 5'd5);
    wait_out("illegal", 1, 32'h00000000, 1'b1);
    consume("illegal");

    // Backpressure then back-to-back accept
    issue("bp", SRL, 32'h000000F0, 5'd4);
    wait_out("bp", 2, 32'h0000000F, 1'b0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_hold_valid", 32'(out_valid), 32'd1);
      chk("bp_hold_result", out_result, 32'h0000000F);
      chk("bp_hold_in_ready", 32'(in_ready), 32'd0);
    end
    out_ready = 1'b1;
    issue("b2b", SLL, 32'h00000001, 5'd1);
    out_ready = 1'b0;
    wait_out("b2b", 2, 32'h00000002, 1'b0);
    consume("b2b");

    // Flush mid-BUSY
    issue("flush_busy", SLL, 32'h00000001, 5'd31);
    @(negedge clk);
    flush = 1'b1;
    #1 chk("flush_in_ready", 32'(in_ready), 32'd0);
    @(negedge clk);
    flush = 1'b0;
    chk("flush_busy_idle", 32'(busy), 32'd0);
    no_output("flush_busy", 12);
    issue("sra8", SRA, 32'hFFFFFF00, 5'd8);
    wait_out("sra8", 3, 32'hFFFFFFFF, 1'b0);
    consume("sra8");

    // Flush drops a presented result even with out_ready high
    issue("flush_done", SRL, 32'hCAFEF00D, 5'd0);
    chk("flush_done_valid", 32'(out_valid), 32'd1);
    flush     = 1'b1;
    out_ready = 1'b1;
    @(negedge clk);
    flush     = 1'b0;
    out_ready = 1'b0;
    chk("flush_done_dropped", 32'(out_valid), 32'd0);
    chk("flush_done_idle", 32'(busy), 32'd0);

    // Asynchronous reset between edges while BUSY
    issue("arst", SLL, 32'h00000001, 5'd31);
    @(negedge clk);
    chk("arst_busy_before", 32'(busy), 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("arst_busy_drop", 32'(busy), 32'd0);
    chk("arst_valid_drop", 32'(out_valid), 32'd0);
    chk("arst_result_clear", out_result, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    #1 chk("arst_in_ready", 32'(in_ready), 32'd1);
    no_output("arst", 12);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
